// File: rtl/scan_ctrl_pkg.sv
// Shared encodings for the scan chain sequencer: op codes and FSM states.
package scan_ctrl_pkg;

  localparam logic [1:0] OP_SHIFT   = 2'd0;
  localparam logic [1:0] OP_CAPTURE = 2'd1;
  localparam logic [1:0] OP_CLEAR   = 2'd2;
  localparam logic [1:0] OP_PRESET  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CAPT   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_PULSE  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

endpackage

// File: rtl/scan_shift_cnt.sv
// Loadable down-counter with zero flag; exposes its next value so the
// sequencer can register outputs that depend on the upcoming count.
module scan_shift_cnt
  import scan_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;
  assign zero_o     = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift / capture / clear / preset ops on one muxed-scan
// chain, with serial scan-out gathered into a parallel response word.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CP,
  input  logic                 RST,
  input  logic                 START,
  input  logic [1:0]           OP,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 TE,
  output logic                 TI,
  output logic                 CHAIN_CLK_EN,
  output logic                 CD_N,
  output logic                 SD_N,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam int CNT_W = $clog2(CHAIN_LEN + CAPTURE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_N = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(CAPTURE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d, pat_sh;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]     cnt_val, cnt_next;
  logic te_q, ti_q, clk_en_q, cd_n_q, sd_n_q, busy_q, done_q;
  logic te_d, ti_d, clk_en_d, cd_n_d, sd_n_d, busy_d, done_d;

  scan_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CP),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_next_o (cnt_next),
    .zero_o     (cnt_zero)
  );

  // FIN doubles as an accept point so back-to-back ops see BUSY low for one cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pat_d    = pat_q;
    cnt_load = 1'b0;
    cnt_val  = LOAD_N;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (START) begin
          op_d     = OP;
          pat_d    = PAT_IN;
          cnt_load = 1'b1;
          case (OP)
            OP_SHIFT:   state_d = ST_UNLOAD;
            OP_CAPTURE: state_d = ST_LOAD;
            default:    state_d = ST_PULSE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_zero) begin
          state_d  = ST_CAPT;
          cnt_load = 1'b1;
          cnt_val  = LOAD_C;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAPT: begin
        if (cnt_zero) begin
          state_d  = ST_UNLOAD;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (cnt_zero) begin
          state_d = ST_FIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned to it.
  always_comb begin
    shadow_d = shadow_q;
    resp_d   = resp_q;
    if (state_q == ST_UNLOAD) begin
      shadow_d    = shadow_q << 1;
      shadow_d[0] = SO;
      if (cnt_zero) begin
        resp_d = shadow_d;
      end else begin
        resp_d = resp_q;
      end
    end else begin
      shadow_d = shadow_q;
    end
    pat_sh   = pat_d >> cnt_next;
    te_d     = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    clk_en_d = te_d || (state_d == ST_CAPT);
    busy_d   = clk_en_d || (state_d == ST_PULSE);
    done_d   = (state_d == ST_FIN);
    cd_n_d   = !((state_d == ST_PULSE) && (op_d == OP_CLEAR));
    sd_n_d   = !((state_d == ST_PULSE) && (op_d == OP_PRESET));
    if ((state_d == ST_LOAD) || ((state_d == ST_UNLOAD) && (op_d == OP_SHIFT))) begin
      ti_d = pat_sh[0];
    end else begin
      ti_d = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SHIFT;
      pat_q    <= '0;
      shadow_q <= '0;
      resp_q   <= '0;
      te_q     <= 1'b0;
      ti_q     <= 1'b0;
      clk_en_q <= 1'b0;
      cd_n_q   <= 1'b1;
      sd_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pat_q    <= pat_d;
      shadow_q <= shadow_d;
      resp_q   <= resp_d;
      te_q     <= te_d;
      ti_q     <= ti_d;
      clk_en_q <= clk_en_d;
      cd_n_q   <= cd_n_d;
      sd_n_q   <= sd_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TE           = te_q;
  assign TI           = ti_q;
  assign CHAIN_CLK_EN = clk_en_q;
  assign CD_N         = cd_n_q;
  assign SD_N         = sd_n_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign RESP_OUT     = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with an 8-flop behavioural chain whose
// functional D input is ~Q; response words are checked through a scoreboard queue.
module tb_scan_chain_ctrl;
  import scan_ctrl_pkg::*;

  logic       CP = 1'b0;
  logic       RST, START;
  logic [1:0] OP;
  logic [7:0] PAT_IN;
  logic       SO;
  logic       TE, TI, CHAIN_CLK_EN, CD_N, SD_N, BUSY, DONE;
  logic [7:0] RESP_OUT;

  logic [7:0] chain;
  logic       preload_en = 1'b0;
  logic [7:0] preload_val = 8'h00;
  logic [7:0] resp_q[$];
  int checks = 0;
  int errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut (
    .CP(CP), .RST(RST), .START(START), .OP(OP), .PAT_IN(PAT_IN), .SO(SO),
    .TE(TE), .TI(TI), .CHAIN_CLK_EN(CHAIN_CLK_EN), .CD_N(CD_N), .SD_N(SD_N),
    .BUSY(BUSY), .DONE(DONE), .RESP_OUT(RESP_OUT)
  );

  always #5 CP = ~CP;

  always @(posedge CP or negedge CD_N or negedge SD_N) begin
    if (!CD_N)             chain <= 8'h00;
    else if (!SD_N)        chain <= 8'hFF;
    else if (preload_en)   chain <= preload_val;
    else if (CHAIN_CLK_EN) chain <= TE ? {chain[6:0], TI} : ~chain;
  end
  assign SO = chain[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] pat, input logic [7:0] exp_resp,
                        input int poke_k, output int done_at, output int te_cnt,
                        output int capt_cnt, output int cd_low, output int sd_low,
                        output logic [7:0] ti_seq);
    done_at = 0; te_cnt = 0; capt_cnt = 0; cd_low = 0; sd_low = 0; ti_seq = 8'h00;
    START = 1'b1; OP = op; PAT_IN = pat;
    resp_q.push_back(exp_resp);
    @(negedge CP);
    START = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (TE) begin
        if (te_cnt < 8) ti_seq = {ti_seq[6:0], TI};
        te_cnt++;
      end
      if (CHAIN_CLK_EN && !TE) capt_cnt++;
      if (!CD_N) cd_low++;
      if (!SD_N) sd_low++;
      if (DONE) begin
        done_at = k;
        chk("busy_in_done", {31'd0, BUSY}, 32'd0);
        chk("resp_out", {24'd0, RESP_OUT}, {24'd0, resp_q.pop_front()});
        break;
      end
      if (k == poke_k) begin
        START = 1'b1; OP = OP_CLEAR;
      end else begin
        START = 1'b0;
      end
      @(negedge CP);
    end
    START = 1'b0;
    chk("done_seen", {31'd0, done_at != 0}, 32'd1);
  endtask

  initial begin
    int done_at, te_cnt, capt_cnt, cd_low, sd_low, dcnt;
    logic [7:0] ti_seq;
    logic [3:0] busy_v, done_v, cdn_v, sdn_v;

    // 1: reset dominates a held START
    RST = 1'b1; START = 1'b1; OP = OP_SHIFT; PAT_IN = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CP);
      chk("reset_ctl", {25'd0, TE, TI, CHAIN_CLK_EN, CD_N, SD_N, BUSY, DONE}, 32'b0001100);
      chk("reset_resp", {24'd0, RESP_OUT}, 32'd0);
    end
    RST = 1'b0; START = 1'b0;
    @(negedge CP);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    preload_en = 1'b1; preload_val = 8'h3C;
    @(negedge CP);
    preload_en = 1'b0;
    chk("preload", {24'd0, chain}, 32'h3C);

    // 2: SHIFT, with a START poke while busy that must be ignored
    run_op(OP_SHIFT, 8'hA5, 8'h3C, 3, done_at, te_cnt, capt_cnt, cd_low, sd_low, ti_seq);
    chk("shift_done_at", done_at, 32'd9);
    chk("shift_te_cnt", te_cnt, 32'd8);
    chk("shift_ti_seq", {24'd0, ti_seq}, 32'hA5);
    chk("shift_poke_ign", cd_low, 32'd0);
    chk("shift_chain", {24'd0, chain}, 32'hA5);
    @(negedge CP);
    chk("shift_idle", {30'd0, BUSY, DONE}, 32'd0);

    // 3: CAPTURE with D = ~Q
    run_op(OP_CAPTURE, 8'h0F, 8'hF0, 0, done_at, te_cnt, capt_cnt, cd_low, sd_low, ti_seq);
    chk("capt_done_at", done_at, 32'd18);
    chk("capt_te_cnt", te_cnt, 32'd16);
    chk("capt_cycles", capt_cnt, 32'd1);
    chk("capt_ti_seq", {24'd0, ti_seq}, 32'h0F);
    chk("capt_chain", {24'd0, chain}, 32'h00);

    // 4: CLEAR then PRESET; response word unchanged
    preload_en = 1'b1; preload_val = 8'h5A;
    @(negedge CP);
    preload_en = 1'b0;
    run_op(OP_CLEAR, 8'h00, 8'hF0, 0, done_at, te_cnt, capt_cnt, cd_low, sd_low, ti_seq);
    chk("clr_done_at", done_at, 32'd2);
    chk("clr_cd_low", cd_low, 32'd1);
    chk("clr_sd_low", sd_low, 32'd0);
    chk("clr_te", te_cnt, 32'd0);
    chk("clr_chain", {24'd0, chain}, 32'h00);
    run_op(OP_PRESET, 8'h00, 8'hF0, 0, done_at, te_cnt, capt_cnt, cd_low, sd_low, ti_seq);
    chk("pre_done_at", done_at, 32'd2);
    chk("pre_sd_low", sd_low, 32'd1);
    chk("pre_cd_low", cd_low, 32'd0);
    chk("pre_chain", {24'd0, chain}, 32'hFF);

    // 5: reset in the middle of a SHIFT
    START = 1'b1; OP = OP_SHIFT; PAT_IN = 8'h5A;
    @(negedge CP);
    START = 1'b0;
    te_cnt = 0;
    for (int k = 0; k < 20 && te_cnt < 4; k++) begin
      if (TE) te_cnt++;
      if (te_cnt < 4) @(negedge CP);
    end
    chk("abort_reached", te_cnt, 32'd4);
    RST = 1'b1;
    @(negedge CP);
    RST = 1'b0;
    chk("abort_ctl", {28'd0, TE, CHAIN_CLK_EN, BUSY, DONE}, 32'd0);
    chk("abort_resp", {24'd0, RESP_OUT}, 32'd0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CP);
      if (DONE || BUSY) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);

    // 6: START held through DONE starts a second op at the DONE edge
    START = 1'b1; OP = OP_CLEAR; PAT_IN = 8'h00;
    @(negedge CP);
    OP = OP_PRESET;
    for (int k = 0; k < 4; k++) begin
      busy_v[3-k] = BUSY; done_v[3-k] = DONE; cdn_v[3-k] = CD_N; sdn_v[3-k] = SD_N;
      if (k < 3) @(negedge CP);
    end
    START = 1'b0;
    chk("b2b_busy", {28'd0, busy_v}, 32'b1010);
    chk("b2b_done", {28'd0, done_v}, 32'b0101);
    chk("b2b_cd_n", {28'd0, cdn_v}, 32'b0111);
    chk("b2b_sd_n", {28'd0, sdn_v}, 32'b1101);
    chk("b2b_chain", {24'd0, chain}, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
